// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types for the LED pattern sequencer.
// Mode encoding and pingpong direction codes.
package led_pkg;

  typedef enum logic [1:0] {
    LED_ROTATE   = 2'd0,
    LED_PINGPONG = 2'd1,
    LED_BINARY   = 2'd2,
    LED_BLINK    = 2'd3
  } led_mode_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_pattern_sequencer_tick_gen.sv
// Step prescaler: counts 0..STEP_CYCLES-1 while en, tick on last count.
// Ports: clk, rst (async high), en, clr (sync clear, wins over en), tick.
module led_tick_gen #(
  parameter int STEP_CYCLES = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: rotate / pingpong / binary / blink at a fixed step rate.
// Ports: clk, rst (async high), en, mode[1:0], opin[NUM_LEDS-1:0], step.
import led_pkg::*;

module led_pattern_sequencer #(
  parameter int NUM_LEDS    = 3,
  parameter int STEP_CYCLES = 27000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] opin,
  output logic                step
);

  if (STEP_CYCLES < 2 || NUM_LEDS < 1) begin : g_bad_params
    $error("led_pattern_sequencer: need STEP_CYCLES>=2, NUM_LEDS>=1");
  end

  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
  localparam logic [IW-1:0] ONE = IW'(1);

  led_mode_t             mode_q, mode_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  dir, dir_n;
  logic [NUM_LEDS-1:0]   opin_n;
  logic                  step_n;
  logic                  chg;
  logic                  tick;

  function automatic logic [NUM_LEDS-1:0] init_pat(
    input led_mode_t m
  );
    logic [NUM_LEDS-1:0] r;
    unique case (m)
      LED_ROTATE,
      LED_PINGPONG: r = NUM_LEDS'(1);
      LED_BINARY:   r = '0;
      LED_BLINK:    r = '1;
      default:      r = NUM_LEDS'(1);
    endcase
    return r;
  endfunction

  function automatic logic [NUM_LEDS-1:0] onehot(
    input logic [IW-1:0] i
  );
    return NUM_LEDS'(1) << i;
  endfunction

  assign chg = (led_mode_t'(mode) != mode_q);

  led_tick_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (chg),
    .tick(tick)
  );

  // A mode change takes priority over a coincident tick and
  // restarts the new pattern from its initial value.
  always_comb begin
    mode_n = mode_q;
    opin_n = opin;
    idx_n  = idx;
    dir_n  = dir;
    step_n = 1'b0;
    if (chg) begin
      mode_n = led_mode_t'(mode);
      opin_n = init_pat(led_mode_t'(mode));
      idx_n  = '0;
      dir_n  = DIR_UP;
    end else if (tick) begin
      step_n = 1'b1;
      unique case (mode_q)
        LED_ROTATE: begin
          idx_n  = (idx == LAST_IDX) ? '0 : idx + ONE;
          opin_n = onehot(idx_n);
        end
        LED_PINGPONG: begin
          // Ends are turned on the spot so each end shows once.
          if (NUM_LEDS == 1) begin
            idx_n = '0;
          end else if (dir == DIR_UP) begin
            if (idx == LAST_IDX) begin
              idx_n = idx - ONE;
              dir_n = DIR_DN;
            end else begin
              idx_n = idx + ONE;
            end
          end else begin
            if (idx == '0) begin
              idx_n = idx + ONE;
              dir_n = DIR_UP;
            end else begin
              idx_n = idx - ONE;
            end
          end
          opin_n = onehot(idx_n);
        end
        LED_BINARY: opin_n = opin + NUM_LEDS'(1);
        LED_BLINK:  opin_n = ~opin;
        default:    opin_n = opin;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= LED_ROTATE;
      opin   <= NUM_LEDS'(1);
      idx    <= '0;
      dir    <= DIR_UP;
      step   <= 1'b0;
    end else begin
      mode_q <= mode_n;
      opin   <= opin_n;
      idx    <= idx_n;
      dir    <= dir_n;
      step   <= step_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer (NUM_LEDS=3, STEP_CYCLES=4).
// Expected step patterns/gaps are queued, then popped at each step pulse.
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] opin;
  logic       step;

  int checks = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  int         gap_q[$];

  led_pattern_sequencer #(
    .NUM_LEDS(3),
    .STEP_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .opin(opin),
    .step(step)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits (bounded) for the next step pulse; gap = negedges waited.
  task automatic wait_step(input int budget, output logic [2:0] o,
                           output int gap, output bit ok);
    ok = 1'b0;
    gap = 0;
    o = '0;
    while (!ok && gap < budget) begin
      @(negedge clk);
      gap++;
      if (step === 1'b1) begin
        o = opin;
        ok = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    mode = m;
    exp_q.delete();
    gap_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    #1;
    checks++;
    if (opin !== 3'b001 || step !== 1'b0) begin
      failures++;
      $display("FAIL reset: opin=%b step=%b want 001/0", opin, step);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (opin !== 3'b001 || step !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_en0: opin=%b step=%b want 001/0", opin, step);
    end
  endtask

  task automatic test_rotate;
    logic [2:0] o, eo;
    int g, eg;
    bit ok;
    do_reset(2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (opin !== 3'b001 || step !== 1'b0) begin
        failures++;
        $display("FAIL rotate_hold%0d: opin=%b step=%b want 001/0", i, opin, step);
      end
    end
    exp_q.push_back(3'b010); gap_q.push_back(1);
    exp_q.push_back(3'b100); gap_q.push_back(4);
    exp_q.push_back(3'b001); gap_q.push_back(4);
    exp_q.push_back(3'b010); gap_q.push_back(4);
    while (exp_q.size() > 0) begin
      eo = exp_q.pop_front();
      eg = gap_q.pop_front();
      wait_step(10, o, g, ok);
      checks++;
      if (!ok || o !== eo || g != eg) begin
        failures++;
        $display("FAIL rotate_step: ok=%0d opin=%b gap=%0d want %b gap %0d", ok, o, g, eo, eg);
      end
    end
  endtask

  task automatic test_pingpong;
    logic [2:0] o, eo;
    int g, eg;
    bit ok;
    do_reset(2'd1);
    @(negedge clk);
    checks++;
    if (opin !== 3'b001 || step !== 1'b0) begin
      failures++;
      $display("FAIL pingpong_resync: opin=%b step=%b want 001/0", opin, step);
    end
    exp_q.push_back(3'b010); gap_q.push_back(4);
    exp_q.push_back(3'b100); gap_q.push_back(4);
    exp_q.push_back(3'b010); gap_q.push_back(4);
    exp_q.push_back(3'b001); gap_q.push_back(4);
    exp_q.push_back(3'b010); gap_q.push_back(4);
    exp_q.push_back(3'b100); gap_q.push_back(4);
    while (exp_q.size() > 0) begin
      eo = exp_q.pop_front();
      eg = gap_q.pop_front();
      wait_step(10, o, g, ok);
      checks++;
      if (!ok || o !== eo || g != eg) begin
        failures++;
        $display("FAIL pingpong_step: ok=%0d opin=%b gap=%0d want %b gap %0d", ok, o, g, eo, eg);
      end
    end
  endtask

  task automatic test_binary;
    logic [2:0] o, eo;
    int g, eg;
    bit ok;
    do_reset(2'd2);
    @(negedge clk);
    checks++;
    if (opin !== 3'b000 || step !== 1'b0) begin
      failures++;
      $display("FAIL binary_resync: opin=%b step=%b want 000/0", opin, step);
    end
    for (int v = 1; v <= 8; v++) begin
      exp_q.push_back(3'(v));
      gap_q.push_back(4);
    end
    while (exp_q.size() > 0) begin
      eo = exp_q.pop_front();
      eg = gap_q.pop_front();
      wait_step(10, o, g, ok);
      checks++;
      if (!ok || o !== eo || g != eg) begin
        failures++;
        $display("FAIL binary_step: ok=%0d opin=%b gap=%0d want %b gap %0d", ok, o, g, eo, eg);
      end
    end
  endtask

  task automatic test_mode_tick_collision;
    logic [2:0] o, eo;
    int g, eg;
    bit ok;
    do_reset(2'd0);
    wait_step(10, o, g, ok);
    checks++;
    if (!ok || o !== 3'b010 || g != 4) begin
      failures++;
      $display("FAIL collide_pre: ok=%0d opin=%b gap=%0d want 010 gap 4", ok, o, g);
    end
    repeat (3) @(negedge clk);
    mode = 2'd3;
    @(negedge clk);
    checks++;
    if (opin !== 3'b111 || step !== 1'b0) begin
      failures++;
      $display("FAIL collide_load: opin=%b step=%b want 111/0", opin, step);
    end
    exp_q.push_back(3'b000); gap_q.push_back(4);
    exp_q.push_back(3'b111); gap_q.push_back(4);
    while (exp_q.size() > 0) begin
      eo = exp_q.pop_front();
      eg = gap_q.pop_front();
      wait_step(10, o, g, ok);
      checks++;
      if (!ok || o !== eo || g != eg) begin
        failures++;
        $display("FAIL blink_step: ok=%0d opin=%b gap=%0d want %b gap %0d", ok, o, g, eo, eg);
      end
    end
  endtask

  task automatic test_pause;
    logic [2:0] o, eo;
    int g, eg;
    bit ok;
    do_reset(2'd0);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (opin !== 3'b001 || step !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold%0d: opin=%b step=%b want 001/0", i, opin, step);
      end
    end
    en = 1'b1;
    exp_q.push_back(3'b010); gap_q.push_back(2);
    exp_q.push_back(3'b100); gap_q.push_back(4);
    while (exp_q.size() > 0) begin
      eo = exp_q.pop_front();
      eg = gap_q.pop_front();
      wait_step(10, o, g, ok);
      checks++;
      if (!ok || o !== eo || g != eg) begin
        failures++;
        $display("FAIL pause_resume: ok=%0d opin=%b gap=%0d want %b gap %0d", ok, o, g, eo, eg);
      end
    end
    en = 1'b0;
    mode = 2'd2;
    @(negedge clk);
    checks++;
    if (opin !== 3'b000 || step !== 1'b0) begin
      failures++;
      $display("FAIL paused_mode_change: opin=%b step=%b want 000/0", opin, step);
    end
    en = 1'b1;
    wait_step(10, o, g, ok);
    checks++;
    if (!ok || o !== 3'b001 || g != 4) begin
      failures++;
      $display("FAIL paused_mode_resume: ok=%0d opin=%b gap=%0d want 001 gap 4", ok, o, g);
    end
  endtask

  task automatic test_async_reset;
    logic [2:0] o, eo;
    int g, eg;
    bit ok;
    do_reset(2'd0);
    exp_q.push_back(3'b010); gap_q.push_back(4);
    exp_q.push_back(3'b100); gap_q.push_back(4);
    while (exp_q.size() > 0) begin
      eo = exp_q.pop_front();
      eg = gap_q.pop_front();
      wait_step(10, o, g, ok);
      checks++;
      if (!ok || o !== eo || g != eg) begin
        failures++;
        $display("FAIL arst_pre: ok=%0d opin=%b gap=%0d want %b gap %0d", ok, o, g, eo, eg);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (opin !== 3'b001 || step !== 1'b0) begin
      failures++;
      $display("FAIL arst_async: opin=%b step=%b want 001/0", opin, step);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(3'b010); gap_q.push_back(4);
    exp_q.push_back(3'b100); gap_q.push_back(4);
    while (exp_q.size() > 0) begin
      eo = exp_q.pop_front();
      eg = gap_q.pop_front();
      wait_step(10, o, g, ok);
      checks++;
      if (!ok || o !== eo || g != eg) begin
        failures++;
        $display("FAIL arst_restart: ok=%0d opin=%b gap=%0d want %b gap %0d", ok, o, g, eo, eg);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    test_reset();
    test_rotate();
    test_pingpong();
    test_binary();
    test_mode_tick_collision();
    test_pause();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
